// File: rtl/seg7_pkg.sv
// Shared definitions for the 3-digit 7-segment display path: converter states,
// digit geometry and the segment decode table used by every seg7 decoder.
package seg7_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_e;

  localparam int NUM_DIGITS = 3;
  localparam int IDX_W      = 2;

  // Active-high segments, bit0 = a ... bit6 = g.
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  function automatic logic [3:0] add3_if_ge5(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Free-running 8-bit binary to 3-digit BCD converter (shift-add-3), one
// conversion every 10 clocks: IDLE (capture), 8x SHIFT, DONE (result strobe).
module bin2bcd_serial
  import seg7_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] value_i,
  output logic [3:0] hund_o,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o,
  output logic       done_o,
  output logic       busy_o
);

  conv_state_e state_q;
  logic [2:0]  iter_q;
  logic [7:0]  bin_q;
  logic [11:0] bcd_q;
  logic        busy_q;
  logic        done_q;
  logic [11:0] bcd_adj_d;

  always_comb begin
    bcd_adj_d = {add3_if_ge5(bcd_q[11:8]), add3_if_ge5(bcd_q[7:4]), add3_if_ge5(bcd_q[3:0])};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      iter_q  <= 3'd0;
      bin_q   <= 8'd0;
      bcd_q   <= 12'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          bin_q   <= value_i;
          bcd_q   <= 12'd0;
          iter_q  <= 3'd0;
          busy_q  <= 1'b1;
          done_q  <= 1'b0;
          state_q <= ST_SHIFT;
        end
        ST_SHIFT: begin
          {bcd_q, bin_q} <= {bcd_adj_d[10:0], bin_q, 1'b0};
          iter_q         <= iter_q + 3'd1;
          if (iter_q == 3'd7) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign hund_o = bcd_q[11:8];
  assign tens_o = bcd_q[7:4];
  assign ones_o = bcd_q[3:0];
  assign done_o = done_q;
  assign busy_o = busy_q;

endmodule

// File: rtl/seg7_scan_driver.sv
// Converts an 8-bit value to BCD and scans the three digits onto one 7-segment
// bus. Optional leading-zero blanking is enabled by defining SEG7_BLANK_EN.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int PRESCALE_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] value,
  output logic [6:0] segments,
  output logic [2:0] digit_en,
  output logic       busy
);

  localparam logic [PRESCALE_W-1:0] PRE_ONE = 1;

  logic [3:0] hund_d, tens_d, ones_d;
  logic       done_d;

  logic [PRESCALE_W-1:0] prescale_q;
  logic [IDX_W-1:0]      idx_q;
  logic [3:0]            hund_q, tens_q, ones_q;
  logic [3:0]            nib_sel;

  bin2bcd_serial u_conv (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .value_i (value),
    .hund_o  (hund_d),
    .tens_o  (tens_d),
    .ones_o  (ones_d),
    .done_o  (done_d),
    .busy_o  (busy)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prescale_q <= '0;
      idx_q      <= '0;
      hund_q     <= 4'd0;
      tens_q     <= 4'd0;
      ones_q     <= 4'd0;
    end else begin
      prescale_q <= prescale_q + PRE_ONE;
      if (done_d) begin
        hund_q <= hund_d;
        tens_q <= tens_d;
        ones_q <= ones_d;
      end
      // Index 3 has no digit; recover from it regardless of the prescaler.
      if (idx_q == 2'd3) begin
        idx_q <= 2'd0;
      end else if (&prescale_q) begin
        idx_q <= (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
      end
    end
  end

  always_comb begin
    digit_en = 3'b000;
    nib_sel  = ones_q;
    case (idx_q)
      2'd0: begin digit_en = 3'b001; nib_sel = ones_q; end
      2'd1: begin digit_en = 3'b010; nib_sel = tens_q; end
      2'd2: begin digit_en = 3'b100; nib_sel = hund_q; end
      default: begin digit_en = 3'b000; nib_sel = ones_q; end
    endcase
  end

`ifdef SEG7_BLANK_EN
  always_comb begin
    segments = seg_decode(nib_sel);
    if (idx_q == 2'd2 && hund_q == 4'd0)
      segments = SEG_BLANK;
    else if (idx_q == 2'd1 && hund_q == 4'd0 && tens_q == 4'd0)
      segments = SEG_BLANK;
  end
`else
  always_comb begin
    segments = seg_decode(nib_sel);
  end
`endif

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a cycle-level arithmetic model pushes
// expected outputs, a negedge monitor pops and compares.
module tb_seg7_scan_driver;
  localparam int PW = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] value = 8'd0;
  logic [6:0] segments;
  logic [2:0] digit_en;
  logic       busy;

  seg7_scan_driver #(.PRESCALE_W(PW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .value    (value),
    .segments (segments),
    .digit_en (digit_en),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       b;
    logic [2:0] en;
    logic [6:0] seg;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Model state: edges since reset release, captured value, displayed digits.
  int k = 0;
  int cap = 0;
  int dh = 0, dt = 0, d_o = 0;

  function automatic logic [6:0] ref_seg(input int d);
    case (d)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic exp_t make_exp(input logic b, input int idx, input int h, input int t, input int o);
    exp_t e;
    int   d;
    d = (idx == 0) ? o : (idx == 1) ? t : h;
    e.b   = b;
    e.en  = 3'b001 << idx;
    e.seg = ref_seg(d);
`ifdef SEG7_BLANK_EN
    if (idx == 2 && h == 0) e.seg = 7'h00;
    if (idx == 1 && h == 0 && t == 0) e.seg = 7'h00;
`endif
    return e;
  endfunction

  always @(posedge clk) begin
    int phase;
    int idx;
    if (!rst_n) begin
      k = 0; dh = 0; dt = 0; d_o = 0;
      exp_q.push_back(make_exp(1'b0, 0, 0, 0, 0));
    end else begin
      phase = k % 10;
      if (phase == 0) cap = int'(value);
      if (phase == 9) begin
        dh = cap / 100; dt = (cap / 10) % 10; d_o = cap % 10;
      end
      idx = ((k + 1) >> PW) % 3;
      exp_q.push_back(make_exp(phase <= 7, idx, dh, dt, d_o));
      k++;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (busy !== e.b) begin
        errors++;
        $display("FAIL busy cyc=%0d got %b exp %b", cyc, busy, e.b);
      end
      checks++;
      if (digit_en !== e.en) begin
        errors++;
        $display("FAIL digit_en cyc=%0d got %b exp %b", cyc, digit_en, e.en);
      end
      checks++;
      if (segments !== e.seg) begin
        errors++;
        $display("FAIL segments cyc=%0d en=%b got %h exp %h", cyc, digit_en, segments, e.seg);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Leaves stimulus just before the edge whose converter phase is p.
  task automatic wait_phase(input int p);
    int guard;
    guard = 0;
    while ((k % 10) != p && guard < 20) begin
      step(1);
      guard++;
    end
    if (guard >= 20) begin
      errors++;
      $display("FAIL wait_phase p=%0d timed out", p);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    value = 8'd200;
    step(2);
    rst_n = 1'b1;
    step(20);

    value = 8'd255;
    step(40);

    wait_phase(0);
    value = 8'd100;
    step(4);
    value = 8'd42;
    step(30);

    value = 8'd7;
    step(30);
    value = 8'd105;
    step(30);
    value = 8'd0;
    step(24);

    value = 8'd255;
    wait_phase(0);
    step(5);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(30);

    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(3, 0) == 0) value = 8'($urandom_range(255, 0));
      if ($urandom_range(149, 0) == 0) begin
        rst_n = 1'b0;
        step(int'($urandom_range(3, 1)));
        rst_n = 1'b1;
      end
      step(1);
    end
    step(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Downstream display stage for the 8-bit free-running counter. Takes the counter's binary value, converts it to three BCD digits with a sequential shift-add-3 converter, and time-multiplexes those digits onto one 7-segment bus with one-hot digit enables. Sits between the counter output and the board's common-cathode 3-digit display.

## Interface

**Parameters**
- `PRESCALE_W`, default 16: scan prescaler width; the scan advances one digit every 2^PRESCALE_W clocks.

**Ports**
- `clk`, input, 1: clock.
- `rst_n`, input, 1: reset; synchronous, active-low.
- `value`, input, 8: unsigned binary value to display (the counter output).
- `segments`, output, 7: active-high segments, bit0 = a … bit6 = g.
- `digit_en`, output, 3: one-hot digit enable, active-high; bit0 = ones, bit1 = tens, bit2 = hundreds.
- `busy`, output, 1: high while the converter is in SHIFT.

## Operation

**Converter FSM: IDLE → SHIFT → DONE → IDLE**
- Runs continuously with a fixed 10-cycle period.
- **IDLE** (1 cycle): capture `value` into an 8-bit shift register and clear the 12-bit BCD accumulator; go to SHIFT.
- **SHIFT** (8 cycles): each cycle, add 3 to every BCD nibble ≥ 5, then shift {BCD, binary} left by 1; a 3-bit iteration counter exits after the 8th shift.
- **DONE** (1 cycle): copy the hundreds, tens and ones nibbles into the display registers; go to IDLE.
- `value` changes outside the IDLE cycle are ignored until the next IDLE.
- Max input 255 gives nibbles 2/5/5. Nibbles are kept 4 bits wide, and all add-3 results fit in 4 bits.

**Scan**
- The prescaler increments every clock and wraps.
- When the prescaler is all-ones, the digit index advances 0→1→2→0. Index 3 is unreachable; if it is ever reached, force it to 0.
- `digit_en` = one-hot(index).
- `segments` = decode(display nibble selected by index).
- Outputs are combinational from registers only: index, display registers, FSM state.

**Decode (hex 0x)**
- 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
- Nibbles 10–15 decode to 00.

**Reset and mid-operation rules**
- Reset asserted at any posedge forces, on that edge:
  - FSM = IDLE, iteration counter = 0, shift/BCD registers = 0
  - display registers = 0, prescaler = 0, index = 0
- Resulting outputs: `digit_en`=001, `segments`=3F, `busy`=0.
- Reset during SHIFT abandons the conversion; the display registers keep 0 until the first post-reset DONE.
- DONE and the prescaler wrap on the same cycle: both take effect. The new digit shows the freshly written nibble.

## Timing

- `value` sampled at IDLE edge N; display registers update at edge N+9; the new value is visible on `segments` from cycle N+9 onward.
- Worst-case latency from a `value` change to display: 19 cycles.
- `busy` is high for exactly cycles N+1 … N+8 of each period.
- Each digit is held for exactly 2^PRESCALE_W cycles. The full refresh frame is 3·2^PRESCALE_W cycles.
- After reset deassertion: first IDLE on the first edge with `rst_n`=1, first index change after 2^PRESCALE_W edges.

## Configuration

**Macro: `SEG7_BLANK_EN`**
- **Defined:** leading-zero blanking.
  - Hundreds digit: `segments`=00 when hundreds = 0.
  - Tens digit: `segments`=00 when hundreds = 0 and tens = 0.
  - Ones digit is never blanked.
  - `digit_en` still cycles normally, so duty cycle is unchanged.
- **Undefined:** all three digits always decoded; no blanking logic is present.

## Structure

**Shared package `seg7_pkg`**
- FSM state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2).
- `NUM_DIGITS`=3.
- Digit-index width = 2.
- Segment constants `SEG_BLANK`=7'h00 and the 0–9 decode values, so the existing seg7 decoder and this block share one table.

**Sub-module `bin2bcd_serial`**
- Contains the FSM, iteration counter and shift/BCD datapath.
- Outputs three nibbles plus a `done` strobe and `busy`.
- The top level holds the display registers, prescaler, index and output mux/decode.

## Test plan

All scenarios use `PRESCALE_W`=2.

1. Reset: hold `rst_n`=0 for 2 cycles with `value`=200 → `digit_en`=001, `segments`=3F, `busy`=0. After release, `busy` rises 1 cycle later and stays high for 8 cycles.
2. `value`=255 held → display registers = 2/5/5 by edge 9. Scan shows 001/6D, 010/6D, 100/5B, each for 4 cycles, then repeats.
3. `value`=100 at IDLE, changed to 42 at SHIFT cycle 3 → first display 1/0/0 (100/06, 010/3F, 001/3F). The next period displays 0/4/2 (001/5B, 010/66, 100/3F or 00 with blanking).
4. With `SEG7_BLANK_EN`, `value`=7 → hundreds 00, tens 00, ones 07. Without it → 3F, 3F, 07.
5. With `SEG7_BLANK_EN`, `value`=105 → hundreds 06, tens 3F (not blanked), ones 6D.
6. Assert reset at SHIFT cycle 4 of converting 255 → next edge: display regs 0, `busy`=0, `digit_en`=001, `segments`=3F. Conversion restarts on release and shows 2/5/5 after 10 cycles.
